// File: rtl/int_controller_if.sv
// Bus between the interrupt controller and its event sources and CPU.
// master drives events, mask writes and ack/reti; slave is the controller.
interface int_controller_if #(
  parameter int N   = 8,
  parameter int IDW = 3
);
  logic [N-1:0]   irqIn;
  logic           maskWe;
  logic [N-1:0]   maskIn;
  logic           ack;
  logic           reti;
  logic           intr;
  logic [IDW-1:0] intID;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;

  modport master (
    output irqIn, maskWe, maskIn, ack, reti,
    input  intr, intID, pending, mask
  );

  modport slave (
    input  irqIn, maskWe, maskIn, ack, reti,
    output intr, intID, pending, mask
  );
endinterface

// File: rtl/int_controller.sv
// Prioritised interrupt controller: latches event pulses, masks them, and runs
// a single request / ack / in-service / reti handshake with the CPU.
module int_controller #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic             clk,
  input  logic             reset,
  int_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_t;

  state_t         state_q;
  logic           intr_q;
  logic [IDW-1:0] intID_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   eligible;
  logic [N-1:0]   clr;
  logic [IDW-1:0] winId;

  // Lowest index wins, so scan from the top down and let lower hits overwrite.
  always_comb begin
    eligible = pending_q & mask_q;
    winId    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winId = IDW'(i);
      end
    end
  end

  // Only an ack accepted in S_REQ clears a bit; a coincident new pulse re-sets it.
  always_comb begin
    clr = '0;
    if (state_q == S_REQ && bus.ack) begin
      clr = N'(1) << intID_q;
    end
    pending_d = (pending_q & ~clr) | bus.irqIn;
    mask_d    = bus.maskWe ? bus.maskIn : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // intID is latched on entry to S_REQ and held until the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      intr_q  <= 1'b0;
      intID_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|eligible) begin
            state_q <= S_REQ;
            intr_q  <= 1'b1;
            intID_q <= winId;
          end
        end
        S_REQ: begin
          if (bus.ack) begin
            state_q <= S_SERVICE;
            intr_q  <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (bus.reti) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.intr    = intr_q;
  assign bus.intID   = intID_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: a cycle-by-cycle vector table
// followed by hand-written latency and reset-during-request sequences.
module tb_int_controller;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic clk;
  logic reset;

  int_controller_if #(.N(N), .IDW(IDW)) bus ();

  int_controller #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic       we;
    logic [7:0] maskV;
    logic       ack;
    logic       reti;
    logic       expIntr;
    logic       chkId;
    logic [2:0] expId;
    logic [7:0] expPend;
    logic [7:0] expMask;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void addVec(logic rst, logic [7:0] irq, logic we, logic [7:0] maskV,
                                 logic ack, logic reti, logic expIntr, logic chkId,
                                 logic [2:0] expId, logic [7:0] expPend, logic [7:0] expMask);
    vec_t v;
    v.rst = rst; v.irq = irq; v.we = we; v.maskV = maskV; v.ack = ack; v.reti = reti;
    v.expIntr = expIntr; v.chkId = chkId; v.expId = expId;
    v.expPend = expPend; v.expMask = expMask;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs away from the edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic rst, input logic [7:0] irq, input logic we,
                               input logic [7:0] maskV, input logic ack, input logic reti);
    @(negedge clk);
    reset      = rst;
    bus.irqIn  = irq;
    bus.maskWe = we;
    bus.maskIn = maskV;
    bus.ack    = ack;
    bus.reti   = reti;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    bus.irqIn  = '0;
    bus.maskWe = 1'b0;
    bus.maskIn = '0;
    bus.ack    = 1'b0;
    bus.reti   = 1'b0;

    //     rst irq    we maskV  ack reti | intr chk id pend   mask
    addVec(1, 8'h00, 0, 8'h00, 0, 0,     0,   1,  0, 8'h00, 8'h00);
    // basic handshake
    addVec(0, 8'h00, 1, 8'hFF, 0, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h08, 0, 8'h00, 0, 0,     0,   0,  0, 8'h08, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  3, 8'h08, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     0,   0,  0, 8'h00, 8'hFF);
    // priority and queueing
    addVec(0, 8'h24, 0, 8'h00, 0, 0,     0,   0,  0, 8'h24, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  2, 8'h24, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h20, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h20, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  5, 8'h20, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  5, 8'h20, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h00, 8'hFF);
    // masking
    addVec(0, 8'h00, 1, 8'hF7, 0, 0,     0,   0,  0, 8'h00, 8'hF7);
    addVec(0, 8'h08, 0, 8'h00, 0, 0,     0,   0,  0, 8'h08, 8'hF7);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     0,   0,  0, 8'h08, 8'hF7);
    addVec(0, 8'h00, 1, 8'hFF, 0, 0,     0,   0,  0, 8'h08, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  3, 8'h08, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h00, 8'hFF);
    // frozen ID and set-wins
    addVec(0, 8'h10, 0, 8'h00, 0, 0,     0,   0,  0, 8'h10, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  4, 8'h10, 8'hFF);
    addVec(0, 8'h02, 0, 8'h00, 0, 0,     1,   1,  4, 8'h12, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  4, 8'h12, 8'hFF);
    addVec(0, 8'h10, 0, 8'h00, 1, 0,     0,   0,  0, 8'h12, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h12, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  1, 8'h12, 8'hFF);
    // ignored strobes: reti in S_REQ, ack in S_SERVICE, ack in S_IDLE
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     1,   1,  1, 8'h12, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h10, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h10, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h10, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  4, 8'h10, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    // reset in S_SERVICE with everything pending; reset beats other strobes
    addVec(0, 8'h01, 0, 8'h00, 0, 0,     0,   0,  0, 8'h01, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  0, 8'h01, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'hFF, 0, 8'h00, 0, 0,     0,   0,  0, 8'hFF, 8'hFF);
    addVec(1, 8'hFF, 1, 8'hAA, 1, 0,     0,   1,  0, 8'h00, 8'h00);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     0,   1,  0, 8'h00, 8'h00);
    // coalescing while in service
    addVec(0, 8'h00, 1, 8'hFF, 0, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h01, 0, 8'h00, 0, 0,     0,   0,  0, 8'h01, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  0, 8'h01, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h40, 0, 8'h00, 0, 0,     0,   0,  0, 8'h40, 8'hFF);
    addVec(0, 8'h40, 0, 8'h00, 0, 0,     0,   0,  0, 8'h40, 8'hFF);
    addVec(0, 8'h40, 0, 8'h00, 0, 0,     0,   0,  0, 8'h40, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h40, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     1,   1,  6, 8'h40, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 1, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 1,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     0,   0,  0, 8'h00, 8'hFF);
    addVec(0, 8'h00, 0, 8'h00, 0, 0,     0,   0,  0, 8'h00, 8'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].irq, vecs[i].we, vecs[i].maskV,
                    vecs[i].ack, vecs[i].reti);
      checkOutput($sformatf("row%0d intr", i), int'(bus.intr), int'(vecs[i].expIntr));
      checkOutput($sformatf("row%0d pending", i), int'(bus.pending), int'(vecs[i].expPend));
      checkOutput($sformatf("row%0d mask", i), int'(bus.mask), int'(vecs[i].expMask));
      if (vecs[i].chkId) begin
        checkOutput($sformatf("row%0d intID", i), int'(bus.intID), int'(vecs[i].expId));
      end
    end

    // Latency from pulse to request for the highest source index, bounded wait.
    applyStimulus(0, 8'h80, 0, 8'h00, 0, 0);
    n = 1;
    while (!bus.intr && n < 6) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
      n++;
    end
    checkOutput("latency cycles", n, 2);
    checkOutput("latency intr", int'(bus.intr), 1);
    checkOutput("latency intID", int'(bus.intID), 7);
    applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
    checkOutput("latency ack pending", int'(bus.pending), 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);

    // Reset while a request is outstanding must drop it with no leftover.
    applyStimulus(0, 8'h04, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
    checkOutput("preReset intr", int'(bus.intr), 1);
    checkOutput("preReset intID", int'(bus.intID), 2);
    applyStimulus(1, 8'h00, 0, 8'h00, 0, 0);
    checkOutput("reqReset intr", int'(bus.intr), 0);
    checkOutput("reqReset intID", int'(bus.intID), 0);
    checkOutput("reqReset pending", int'(bus.pending), 0);
    applyStimulus(0, 8'h00, 1, 8'hFF, 0, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
    checkOutput("postReset intr", int'(bus.intr), 0);
    checkOutput("postReset mask", int'(bus.mask), 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
